// File: rtl/vfm_core_link_pkg.sv
// Shared link definitions: status bit positions, default sizes and a status helper.
package vfm_core_link_pkg;

    localparam int DW_DEF     = 14;
    localparam int DEPTH_DEF  = 8;

    localparam int TX_ACK     = 0;
    localparam int TX_FULL    = 1;
    localparam int TX_PEND    = 2;
    localparam int RX_NE      = 0;
    localparam int RX_FULL    = 1;
    localparam int RX_UNF     = 2;
    localparam int RX_OCC_LSB = 3;
    localparam int STATS_LSB  = 8;

    // The occupancy field is only four bits wide, so larger counts clamp at 15.
    function automatic logic [3:0] occ_sat4(input logic [31:0] occ);
        logic [3:0] res;
        res = occ[3:0];
        if (occ >= 32'd15) begin
            res = 4'hF;
        end
        return res;
    endfunction

endpackage

// File: rtl/vfm_link_fifo.sv
// Synchronous FIFO for the core link; qualifies push/pop itself and reports what it accepted.
import vfm_core_link_pkg::*;

module vfm_link_fifo #(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          push_acc_o,
    output logic          pop_acc_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   occ_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          do_push, do_pop;

    assign full_o  = (occ_q == (AW+1)'(DEPTH));
    assign empty_o = (occ_q == '0);

    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign push_acc_o = do_push;
    assign pop_acc_o  = do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage carries data only; emptiness masks stale contents after reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/vfm_core_link.sv
// Toggle-handshaked inter-core mailbox link. Optional push counter on tx_status[13:8]
// is enabled by defining VFM_LINK_STATS_EN.
import vfm_core_link_pkg::*;

module vfm_core_link #(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock_pin,
    input  logic          Reset_pin,
    input  logic [DW-1:0] tx_data,
    input  logic [DW-1:0] tx_ctrl,
    output logic [DW-1:0] tx_status,
    output logic [DW-1:0] rx_data,
    input  logic [DW-1:0] rx_ctrl,
    output logic [DW-1:0] rx_status
);

    logic        push_tog_q, push_tog_d;
    logic        pop_tog_q, pop_tog_d;
    logic        ack_q, ack_d;
    logic        pend_q, pend_d;
    logic        unf_q, unf_d;
    logic        push_ev, pop_ev;
    logic        push_acc, pop_acc;
    logic        full, empty;
    logic [AW:0] occ;
    logic [5:0]  stats_q;
    logic        unused_ctrl;

    assign unused_ctrl = ^{tx_ctrl[DW-1:1], rx_ctrl[DW-1:1], pop_acc};

    // An event is any level difference between the core's toggle and our tracker.
    assign push_ev = tx_ctrl[0] ^ push_tog_q;
    assign pop_ev  = rx_ctrl[0] ^ pop_tog_q;

    vfm_link_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i      (Clock_pin),
        .rst_i      (Reset_pin),
        .push_i     (push_ev),
        .pop_i      (pop_ev),
        .wdata_i    (tx_data),
        .rdata_o    (rx_data),
        .push_acc_o (push_acc),
        .pop_acc_o  (pop_acc),
        .full_o     (full),
        .empty_o    (empty),
        .occ_o      (occ)
    );

    // A blocked push keeps its tracker unchanged so the event re-fires every edge until space.
    always_comb begin
        push_tog_d = push_tog_q;
        pop_tog_d  = rx_ctrl[0];
        ack_d      = ack_q ^ push_acc;
        pend_d     = push_ev & ~push_acc;
        unf_d      = unf_q | (pop_ev & empty);
        if (push_acc) begin
            push_tog_d = tx_ctrl[0];
        end
    end

    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            push_tog_q <= 1'b0;
            pop_tog_q  <= 1'b0;
            ack_q      <= 1'b0;
            pend_q     <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            push_tog_q <= push_tog_d;
            pop_tog_q  <= pop_tog_d;
            ack_q      <= ack_d;
            pend_q     <= pend_d;
            unf_q      <= unf_d;
        end
    end

`ifdef VFM_LINK_STATS_EN
    logic [5:0] stats_d;

    assign stats_d = stats_q + {5'd0, push_acc};

    always_ff @(posedge Clock_pin or posedge Reset_pin) begin
        if (Reset_pin) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end
`else
    assign stats_q = '0;
`endif

    // Status words are packed wide and truncated so narrow DW builds stay legal.
    logic [DW+15:0] tx_w, rx_w;

    always_comb begin
        tx_w                  = '0;
        tx_w[TX_ACK]          = ack_q;
        tx_w[TX_FULL]         = full;
        tx_w[TX_PEND]         = pend_q;
        tx_w[STATS_LSB +: 6]  = stats_q;
        rx_w                  = '0;
        rx_w[RX_NE]           = ~empty;
        rx_w[RX_FULL]         = full;
        rx_w[RX_UNF]          = unf_q;
        rx_w[RX_OCC_LSB +: 4] = occ_sat4(32'(occ));
    end

    assign tx_status = tx_w[DW-1:0];
    assign rx_status = rx_w[DW-1:0];

endmodule

// File: tb/tb_vfm_core_link.sv
// Self-checking bench for vfm_core_link: directed scenarios plus randomized traffic vs a queue model.
module tb_vfm_core_link;

    localparam int DW    = 14;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] tx_ctrl = '0;
    logic [DW-1:0] rx_ctrl = '0;
    logic [DW-1:0] tx_status, rx_data, rx_status;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int q[$];
    bit m_txlvl, m_rxlvl, m_ack, m_unf, m_pend;
    int m_stats;

    vfm_core_link #(.DW(DW), .DEPTH(DEPTH)) dut (
        .Clock_pin (clk),
        .Reset_pin (rst),
        .tx_data   (tx_data),
        .tx_ctrl   (tx_ctrl),
        .tx_status (tx_status),
        .rx_data   (rx_data),
        .rx_ctrl   (rx_ctrl),
        .rx_status (rx_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_stats();
`ifdef VFM_LINK_STATS_EN
        return m_stats % 64;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        q.delete();
        m_txlvl = 0; m_rxlvl = 0; m_ack = 0; m_unf = 0; m_pend = 0; m_stats = 0;
    endtask

    task automatic check_all(input string tag);
        int occ, exr, ext, exd;
        occ = q.size();
        exr = (occ > 15 ? 15 : occ) * 8 + int'(m_unf) * 4 + (occ == DEPTH ? 2 : 0) + (occ > 0 ? 1 : 0);
        ext = exp_stats() * 256 + int'(m_pend) * 4 + (occ == DEPTH ? 2 : 0) + int'(m_ack);
        exd = (occ > 0) ? q[0] : 0;
        chk({tag, ".rx_status"}, 32'(rx_status), 32'(exr));
        chk({tag, ".tx_status"}, 32'(tx_status), 32'(ext));
        chk({tag, ".rx_data"},   32'(rx_data),   32'(exd));
    endtask

    // One clock edge: model consumes the inputs present at the edge, then outputs are compared.
    task automatic cycle(input string tag);
        bit push_req, pop_req, pop_ok, push_ok;
        @(posedge clk);
        push_req = (tx_ctrl[0] != m_txlvl);
        pop_req  = (rx_ctrl[0] != m_rxlvl);
        pop_ok   = pop_req && (q.size() > 0);
        if (pop_req && q.size() == 0) m_unf = 1;
        m_rxlvl  = rx_ctrl[0];
        push_ok  = push_req && ((q.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(q.pop_front());
        if (push_ok) begin
            q.push_back(int'(tx_data));
            m_ack   = ~m_ack;
            m_txlvl = tx_ctrl[0];
            m_stats++;
        end
        m_pend = push_req && !push_ok;
        #1;
        check_all(tag);
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        tx_data    = d;
        tx_ctrl[0] = ~tx_ctrl[0];
    endtask

    task automatic do_pop();
        rx_ctrl[0] = ~rx_ctrl[0];
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        tx_ctrl = '0;
        rx_ctrl = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.tx_status", 32'(tx_status), 32'd0);
        chk("rst.rx_status", 32'(rx_status), 32'd0);
        chk("rst.rx_data",   32'(rx_data),   32'd0);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #2;
        do_reset();

        // Single push lands one edge after the toggle
        do_push(14'h0A5);
        cycle("one");
        chk("one.ne",   32'(rx_status[0]),   32'd1);
        chk("one.data", 32'(rx_data),        32'h0A5);
        chk("one.ack",  32'(tx_status[0]),   32'd1);
        chk("one.occ",  32'(rx_status[6:3]), 32'd1);

        // Fill, blocked push, then pop releases it on the same edge
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            do_push(DW'(i));
            cycle("fill");
        end
        chk("fill.rxfull", 32'(rx_status[1]), 32'd1);
        chk("fill.txfull", 32'(tx_status[1]), 32'd1);
        do_push(DW'(9));
        cycle("blk");
        chk("blk.pend", 32'(tx_status[2]), 32'd1);
        chk("blk.ack",  32'(tx_status[0]), 32'd0);
        cycle("blk2");
        chk("blk2.pend", 32'(tx_status[2]), 32'd1);
        do_pop();
        cycle("rel");
        chk("rel.occ",  32'(rx_status[6:3]), 32'd8);
        chk("rel.pend", 32'(tx_status[2]),   32'd0);
        chk("rel.ack",  32'(tx_status[0]),   32'd1);
        for (int v = 2; v <= 9; v++) begin
            chk("drain.data", 32'(rx_data), 32'(v));
            do_pop();
            cycle("drain");
        end
        chk("drain.empty", 32'(rx_status[0]), 32'd0);

        // Simultaneous push and pop at occupancy 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_push(DW'(16 + i));
            cycle("sim.fill");
        end
        do_push(DW'(40));
        do_pop();
        cycle("sim");
        chk("sim.occ",  32'(rx_status[6:3]), 32'd3);
        chk("sim.head", 32'(rx_data),        32'd17);
        for (int v = 0; v < 3; v++) begin
            do_pop();
            cycle("sim.drain");
        end
        chk("sim.tail", 32'(rx_status[0]), 32'd0);

        // Underflow sticky survives traffic, clears only on reset
        do_reset();
        do_pop();
        cycle("unf");
        chk("unf.set", 32'(rx_status[2]), 32'd1);
        do_push(DW'(7));
        cycle("unf.push");
        do_pop();
        cycle("unf.pop");
        chk("unf.hold", 32'(rx_status[2]), 32'd1);
        do_reset();
        chk("unf.clr", 32'(rx_status[2]), 32'd0);

        // Asynchronous reset mid-stream at occupancy 5
        for (int i = 0; i < 5; i++) begin
            do_push(DW'(100 + i));
            cycle("ar.fill");
        end
        chk("ar.occ", 32'(rx_status[6:3]), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.tx_status", 32'(tx_status), 32'd0);
        chk("ar.rx_status", 32'(rx_status), 32'd0);
        chk("ar.rx_data",   32'(rx_data),   32'd0);
        do_reset();
        do_push(DW'(14'h123));
        cycle("ar.after");
        chk("ar.after.data", 32'(rx_data), 32'h123);

        // 70 accepted pushes with interleaved pops
        do_reset();
        for (int i = 0; i < 70; i++) begin
            do_push(DW'(i));
            do_pop();
            cycle("stats");
        end
`ifdef VFM_LINK_STATS_EN
        chk("stats70", 32'(tx_status[13:8]), 32'd6);
`else
        chk("stats70", 32'(tx_status[13:8]), 32'd0);
`endif

        // Randomized traffic with phase-varying push/pop bias and noisy upper ctrl bits
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int pp, pq;
            pp = ((c / 200) % 3 == 0) ? 80 : 40;
            pq = ((c / 200) % 3 == 1) ? 80 : 35;
            tx_ctrl[DW-1:1] = (DW-1)'($urandom);
            rx_ctrl[DW-1:1] = (DW-1)'($urandom);
            if (tx_ctrl[0] == m_txlvl && $urandom_range(99) < pp) do_push(DW'($urandom));
            if ($urandom_range(99) < pq) do_pop();
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vfm_core_link.md
Name: vfm_core_link

Overview:
- Point-to-point inter-core mailbox channel. It sits between a producer core's Out port pair and a consumer core's In port pair in the multicore top level.
- Replaces the direct ack/data wiring with a buffered, toggle-handshaked FIFO, so the producer can post several words without waiting for the consumer.
- One instance per direction per core pair. Example: core0 Out1/Out2 feed the link, and the link drives core1 In1/In2.

Parameters:
- DW, 14, data width; matches core In/Out port width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, log2(DEPTH); pointer width.

Ports:
- Clock_pin  in  1  core clock.
- Reset_pin  in  1  asynchronous, active-high reset.
- tx_data  in  DW  producer OutK data word.
- tx_ctrl  in  DW  producer OutK-1 control; bit0 = push toggle; other bits ignored.
- tx_status  out  DW  to producer InK-1: bit0 push-ack toggle, bit1 full, bit2 push pending, [13:8] word count (LINK_STATS_EN only).
- rx_data  out  DW  to consumer InK: FIFO head; 0 when empty.
- rx_ctrl  in  DW  consumer OutK-1 control; bit0 = pop toggle.
- rx_status  out  DW  to consumer InK-1: bit0 not-empty, bit1 full, bit2 underflow sticky, [6:3] occupancy (saturating at 15).

Behaviour:
- One clock domain. Reset is asynchronous and active-high. All state and outputs reset to 0: pointers, occupancy, push/pop toggle trackers, ack toggle, sticky bits and the stats counter. Cores drive their Out registers to 0 on reset, so trackers at 0 generate no spurious event.
- Push event: tx_ctrl[0] != push_tog_q while the FIFO is not full.
  - At that edge: write mem[wr_ptr] <= tx_data, advance wr_ptr mod DEPTH, set push_tog_q <= tx_ctrl[0], toggle tx_status[0].
- Push while full: the event stays pending, tx_status[2]=1, and nothing is dropped. It is accepted on the first edge with space, using the tx_data value present on that edge.
- Pop event: rx_ctrl[0] != pop_tog_q.
  - If not empty: advance rd_ptr and set pop_tog_q <= rx_ctrl[0].
  - If empty: set pop_tog_q <= rx_ctrl[0] and set underflow sticky. The sticky bit clears only on reset.
- Simultaneous push and pop: both succeed; occupancy is unchanged. When full, a same-edge pop frees the slot, so the push is also accepted on that edge.
- Latency: a core writes its Out on edge N; the link acts on edge N+1. rx_status and rx_data reflect the new state after edge N+1, with no extra register stage on outputs.
- rx_data and rx_status are decoded from registered state only. No input-to-output combinational path is allowed.
- Occupancy range is 0..DEPTH. full = (occ==DEPTH); empty = (occ==0).
- Pointers wrap naturally at DEPTH. Occupancy must never exceed DEPTH or underflow below 0.
- Unused status bits read 0.
- Reset mid-transfer: all buffered words are discarded. No requirement to preserve data.

Optional Feature:
- Macro: VFM_LINK_STATS_EN.
- Defined: a 6-bit wrapping counter increments on every accepted push and is exposed on tx_status[13:8]. Reset value 0; wraps 63->0.
- Undefined: tx_status[13:8] tied to 0 and the counter is not synthesized.

Decomposition:
- Shared include header vfm_link_defs.vh holds:
  - status bit-position constants: TX_ACK=0, TX_FULL=1, TX_PEND=2, RX_NE=0, RX_FULL=1, RX_UNF=2, RX_OCC_LSB=3, STATS_LSB=8;
  - default DW and DEPTH values.
- One sub-module, vfm_link_fifo: a synchronous FIFO with push/pop/full/empty/occupancy and an asynchronous active-high reset.
- The top block vfm_core_link keeps toggle detection, pending logic, sticky bits and status packing.

Test Plan:
- Reset, then one push toggle with tx_data=14'h0A5 -> rx_status[0]=1, rx_data=14'h0A5, tx_status[0]=1, occupancy=1, all one edge after the toggle.
- 8 pushes (values 1..8) with no pops -> full=1 in both statuses. A 9th toggle with data 9 -> tx_status[2]=1 and no ack change. One pop -> data 9 is accepted on the same edge and occupancy stays 8. Pops then return 2..9 in order.
- Push and pop toggles on the same cycle at occupancy 3 -> occupancy stays 3, head advances and the new word lands at the tail.
- Pop toggle while empty -> rx_status[2]=1 and stays set through subsequent pushes and pops until Reset_pin pulses.
- Reset_pin asserted mid-stream with occupancy 5 -> all outputs 0 immediately (asynchronous). After release, a push toggle from 0 to 1 is accepted normally.
- With VFM_LINK_STATS_EN, 70 accepted pushes (with pops interleaved) -> tx_status[13:8]=6. Without the macro -> bits read 0.
